// File: rtl/in_decode_pkg.sv
// Shared types for the in_decode command dispatcher: opcodes, FSM states and the
// queued command record.
package in_decode_pkg;

  localparam int unsigned OpW   = 3;
  localparam int unsigned DataW = 32;

  typedef enum logic [OpW-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_SIN = 3'b011,
    OP_COS = 3'b100
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } state_t;

  typedef struct packed {
    opcode_t          op;
    logic [DataW-1:0] a;
    logic [DataW-1:0] b;
  } cmd_t;

  // Encodings 101-111 may sit in the FIFO; they are discarded at dispatch.
  function automatic logic op_legal(opcode_t op);
    return (OpW'(op) <= OpW'(OP_COS));
  endfunction

endpackage

// File: rtl/in_decode_if.sv
// Bus between the CPU/arithmetic units (master side) and the in_decode dispatcher
// (slave side).
interface in_decode_if;

  logic        cpu_push;
  logic [2:0]  cpu_opcode;
  logic [31:0] cpu_a;
  logic [31:0] cpu_b;
  logic        add_done;
  logic        mul_done;
  logic        sine_done;
  logic        out_fifo_hold;

  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] sine_in;
  logic        add_start;
  logic        mul_start;
  logic        sine_start;
  logic        add_sub;
  logic        sine_cos;
  logic        op_push;
  logic [2:0]  op_code;
  logic        cmd_full;
  logic        cmd_empty;
  logic        cmd_drop;
  logic        bad_op;
  logic        busy;

  modport master (
    output cpu_push, cpu_opcode, cpu_a, cpu_b, add_done, mul_done, sine_done, out_fifo_hold,
    input  add_a, add_b, mul_a, mul_b, sine_in, add_start, mul_start, sine_start, add_sub,
    input  sine_cos, op_push, op_code, cmd_full, cmd_empty, cmd_drop, bad_op, busy
  );

  modport slave (
    input  cpu_push, cpu_opcode, cpu_a, cpu_b, add_done, mul_done, sine_done, out_fifo_hold,
    output add_a, add_b, mul_a, mul_b, sine_in, add_start, mul_start, sine_start, add_sub,
    output sine_cos, op_push, op_code, cmd_full, cmd_empty, cmd_drop, bad_op, busy
  );

endinterface

// File: rtl/in_decode_cmd_fifo.sv
// Command FIFO: circular buffer with registered full/empty/drop flags and a
// combinational head output.
module in_decode_cmd_fifo
  import in_decode_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  cmd_t din_i,
  output cmd_t dout_o,
  output logic full_o,
  output logic empty_o,
  output logic drop_o
);

  localparam int unsigned PtrW = $clog2(DEPTH) + 1;
  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam logic [PtrW-1:0] CntFull = PtrW'(DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);

  cmd_t            mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] cnt_q, cnt_d;
  logic            full_q, empty_q, drop_q;
  logic            wr_en, rd_en;

  // Full is judged on the pre-edge count, so a pop in the same cycle cannot rescue a push.
  always_comb begin
    wr_en  = push_i && (cnt_q != CntFull);
    rd_en  = pop_i && (cnt_q != '0);
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_en) wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + 1'b1;
    if (rd_en) rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + 1'b1;
    if (wr_en && !rd_en) cnt_d = cnt_q + 1'b1;
    if (!wr_en && rd_en) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      drop_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CntFull);
      empty_q <= (cnt_d == '0);
      drop_q  <= push_i && !wr_en;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[IdxW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q[IdxW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign drop_o  = drop_q;

endmodule

// File: rtl/in_decode.sv
// Input dispatcher: pops queued commands, drives operands and a start strobe to the
// target unit, and records the opcode for the output stage. One operation in flight.
module in_decode
  import in_decode_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  in_decode_if.slave bus
);

  state_t      state_q, state_d;
  opcode_t     op_q;
  cmd_t        fifo_din, head;
  logic        fifo_full, fifo_empty, fifo_drop;
  logic        pop, issue, discard, target_done;
  logic        bad_op_q;
  logic [31:0] add_a_q, add_b_q, mul_a_q, mul_b_q, sine_in_q;

  assign fifo_din = '{op: opcode_t'(bus.cpu_opcode), a: bus.cpu_a, b: bus.cpu_b};

  in_decode_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_cmd_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (bus.cpu_push),
    .pop_i  (pop),
    .din_i  (fifo_din),
    .dout_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .drop_o (fifo_drop)
  );

  always_comb begin
    unique case (op_q)
      OP_ADD, OP_SUB: target_done = bus.add_done;
      OP_MUL:         target_done = bus.mul_done;
      default:        target_done = bus.sine_done;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    issue   = 1'b0;
    discard = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Hold only gates dispatch here; an operation already issued runs to completion.
        if (!fifo_empty && !bus.out_fifo_hold) begin
          pop = 1'b1;
          if (op_legal(head.op)) begin
            issue   = 1'b1;
            state_d = ISSUE;
          end else begin
            discard = 1'b1;
          end
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (target_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      bad_op_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bad_op_q <= discard;
      if (issue) op_q <= head.op;
    end
  end

  // Only the selected unit's operands are loaded; the others keep their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a_q   <= '0;
      add_b_q   <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      sine_in_q <= '0;
    end else if (issue) begin
      unique case (head.op)
        OP_ADD, OP_SUB: begin
          add_a_q <= head.a;
          add_b_q <= head.b;
        end
        OP_MUL: begin
          mul_a_q <= head.a;
          mul_b_q <= head.b;
        end
        default: sine_in_q <= head.a;
      endcase
    end
  end

  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.sine_in    = sine_in_q;
  assign bus.add_start  = (state_q == ISSUE) && ((op_q == OP_ADD) || (op_q == OP_SUB));
  assign bus.mul_start  = (state_q == ISSUE) && (op_q == OP_MUL);
  assign bus.sine_start = (state_q == ISSUE) && ((op_q == OP_SIN) || (op_q == OP_COS));
  assign bus.add_sub    = (op_q == OP_SUB);
  assign bus.sine_cos   = (op_q == OP_COS);
  assign bus.op_push    = (state_q == ISSUE);
  assign bus.op_code    = 3'(op_q);
  assign bus.cmd_full   = fifo_full;
  assign bus.cmd_empty  = fifo_empty;
  assign bus.cmd_drop   = fifo_drop;
  assign bus.bad_op     = bad_op_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: doc/in_decode.md
# in_decode

System-level input dispatcher; the command-side counterpart of the output collector. The CPU pushes {opcode, operand A, operand B} into an internal command FIFO. An FSM pops one command at a time, drives the operands and a one-cycle start strobe to the adder, multiplier or sine unit, and pushes the opcode into the op FIFO that the output stage later pops. The output stage uses that opcode to route the matching result. Only one operation is in flight at a time.

## Interface
- DEPTH, 4, command FIFO entries; power of two, 2..16
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous and active-high (already decided)
- cpu_push  in  1  command write strobe
- cpu_opcode  in  3  000 add, 001 sub, 010 mul, 011 sin, 100 cos; 101-111 illegal
- cpu_a, cpu_b  in  32  IEEE-754 single operands; cpu_b is ignored for sin/cos
- add_done, mul_done, sine_done  in  1  unit completion pulses
- out_fifo_hold  in  1  output stage full; blocks new issue
- add_a, add_b, mul_a, mul_b, sine_in  out  32  registered operands
- add_start, mul_start, sine_start  out  1  one-cycle start pulses
- add_sub  out  1  1 = subtract; valid while add_start is high
- sine_cos  out  1  1 = cosine; valid while sine_start is high
- op_push  out  1  one-cycle push into the op FIFO
- op_code  out  3  opcode accompanying op_push
- cmd_full, cmd_empty  out  1  command FIFO status
- cmd_drop  out  1  one-cycle pulse when a push is rejected
- bad_op  out  1  one-cycle pulse when an illegal opcode is discarded
- busy  out  1  high in ISSUE and WAIT

## Operation
- Command FIFO: circular buffer of DEPTH entries, each {opcode, a, b}.
  - Write pointer, read pointer and count are each $clog2(DEPTH)+1 bits wide.
  - Pointers wrap modulo DEPTH.
- Push rules:
  - A push with cmd_full=1 is dropped and pulses cmd_drop. Full is judged on the pre-edge count, even if a pop happens in the same cycle.
  - A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE → ISSUE when cmd_empty=0 and out_fifo_hold=0. On that edge the head entry is popped into the operand registers.
  - If the head opcode is illegal, it is popped, bad_op pulses, no start is issued, and the FSM stays in IDLE.
  - ISSUE (always one cycle) → WAIT.
    - In ISSUE, exactly one start pulse goes to the target unit.
    - In the same cycle, op_push=1 with op_code equal to the issued opcode.
  - WAIT → IDLE on the done pulse of the target unit only. Done pulses from other units are ignored in every state.
- Operand registers for the unused units hold their previous value. Registers for the selected unit are stable from ISSUE until the next issue.
- Reset values (all outputs and internal state):
  - Every output is 0, except cmd_empty=1.
  - FIFO pointers and count are 0; the FSM is in IDLE.
- Reset asserted mid-operation: the FIFO is flushed and the FSM returns to IDLE. A late done pulse after reset is ignored, because the FSM is in IDLE.

## Timing
- A push at edge N is visible as cmd_empty=0 after edge N.
- From an idle, empty FIFO, the start pulse and op_push are high during the cycle after edge N+1. Minimum push-to-start latency is 2 cycles.
- Done sampled at edge M returns the FSM to IDLE. The next start is high after edge M+1 at the earliest, giving a 2-cycle minimum done-to-start gap.
- out_fifo_hold is sampled only in IDLE. Once in ISSUE or WAIT, hold has no effect.
- An illegal opcode consumes 1 IDLE cycle per entry.
- cmd_full, cmd_empty and busy are registered, with no combinational paths from inputs to outputs.

## Structure
- Package in_decode_pkg holds:
  - opcode_t enum (OP_ADD, OP_SUB, OP_MUL, OP_SIN, OP_COS)
  - state_t enum (IDLE, ISSUE, WAIT)
  - cmd_t struct {opcode_t op; logic [31:0] a, b}
- Sub-module cmd_fifo (parameter DEPTH):
  - Inputs: push, pop, din.
  - Outputs: dout (head entry, combinational), full, empty, drop.
- The top level holds the FSM, the operand registers and the strobe logic.

## Test plan
- Reset, then push add (a=0x3F800000, b=0x40000000) → 2 cycles later add_start=1, add_a/add_b match, op_push=1 with op_code=000; WAIT until add_done, then busy=0.
- Push 5 commands with DEPTH=4 and no done pulses → cmd_full=1 after the 4th push is not enough: the first command pops into ISSUE, so 4 are stored; the 6th push gives cmd_drop=1 for one cycle and the count stays 4.
- Push sub, then cos, with out_fifo_hold=1 → no start is issued; release hold → add_start with add_sub=1, and after add_done, sine_start with sine_cos=1, op_code=100.
- Push opcode 111 followed by mul → bad_op pulses once, with no start and no op_push; mul_start follows 1 cycle later.
- In WAIT for mul, pulse add_done and sine_done → the FSM stays in WAIT; mul_done → IDLE.
- Assert rst during WAIT with 3 commands queued → all outputs reset, cmd_empty=1; a mul_done after reset causes no state change.
